// File: rtl/wb_stage.sv
// Write-back stage: drives the regfile write port and forwarding bus from the stage register,
// and records every retired instruction in a small first-word fall-through trace buffer.
module wb_stage #(
  parameter int unsigned MS_TO_WS_BUS_WD = 102,
  parameter int unsigned WS_TO_RF_BUS_WD = 38,
  parameter int unsigned TRACE_DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       flush,
  input  logic [5:0]                 stall,
  input  logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [WS_TO_RF_BUS_WD-1:0] ws_to_rf_bus,
  output logic [37:0]                ws_to_es_bus,
  output logic                       stallreq_trace,
  output logic                       debug_valid,
  input  logic                       debug_ready,
  output logic [31:0]                debug_wb_pc,
  output logic [3:0]                 debug_wb_rf_we,
  output logic [4:0]                 debug_wb_rf_wnum,
  output logic [31:0]                debug_wb_rf_wdata
);

  localparam int unsigned PtrW = (TRACE_DEPTH > 1) ? $clog2(TRACE_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(TRACE_DEPTH + 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(TRACE_DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } entry_t;

  logic [MS_TO_WS_BUS_WD-1:0] ws_bus_q, ws_bus_d;
  logic                       ws_pushed_q, ws_pushed_d;
  logic [PtrW-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]            count_q, count_d;
  entry_t                     mem_q [TRACE_DEPTH];

  logic        ws_reg_we;
  logic [4:0]  ws_dest;
  logic [31:0] ws_result;
  logic [31:0] ws_pc;
  logic        ws_valid;
  logic        ws_update;
  logic        rf_we;
  logic        full;
  logic        empty;
  logic        push;
  logic        pop;
  entry_t      entry_in;
  entry_t      head;

  assign ws_reg_we = ws_bus_q[101];
  assign ws_dest   = ws_bus_q[100:96];
  assign ws_result = ws_bus_q[95:64];
  assign ws_pc     = ws_bus_q[63:32];

  // A zero pc marks a bubble; the stage register is cleared rather than carrying a valid bit.
  assign ws_valid = (ws_pc != 32'h0);
  assign rf_we    = ws_valid & ws_reg_we & (ws_dest != 5'd0);

  assign ws_to_rf_bus = WS_TO_RF_BUS_WD'({rf_we, ws_dest, ws_result});
  assign ws_to_es_bus = {rf_we, ws_dest, ws_result};

  assign full  = (count_q == FullCnt);
  assign empty = (count_q == '0);
  assign pop   = ~empty & debug_ready;
  assign push  = ws_valid & ~ws_pushed_q & (~full | pop);

  assign stallreq_trace = ws_valid & ~ws_pushed_q & full & ~pop;

  assign entry_in = '{pc: ws_pc, we: {4{rf_we}}, wnum: ws_dest, wdata: ws_result};

  // Any load or clear of the stage register brings in a new (or no) instruction.
  assign ws_update = flush | ~stall[4] | ~stall[5];

  always_comb begin
    ws_bus_d = ws_bus_q;
    if (flush) begin
      ws_bus_d = '0;
    end else if (!stall[4]) begin
      ws_bus_d = ms_to_ws_bus;
    end else if (!stall[5]) begin
      ws_bus_d = '0;
    end
    ws_pushed_d = ws_update ? 1'b0 : (ws_pushed_q | push);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PtrW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PtrW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ws_bus_q    <= '0;
      ws_pushed_q <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      ws_bus_q    <= ws_bus_d;
      ws_pushed_q <= ws_pushed_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage is not reset; the head is masked to zero while the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= entry_in;
    end
  end

  assign head = empty ? '0 : mem_q[rd_ptr_q];

  assign debug_valid       = ~empty;
  assign debug_wb_pc       = head.pc;
  assign debug_wb_rf_we    = head.we;
  assign debug_wb_rf_wnum  = head.wnum;
  assign debug_wb_rf_wdata = head.wdata;

  logic unused_bits;
  assign unused_bits = ^{ws_bus_q[31:0], stall[3:0]};

endmodule

// File: tb/tb_wb_stage.sv
// Randomised and directed bench for wb_stage against a queue-based model of the retire trace.
module tb_wb_stage;

  logic         clk = 1'b0;
  logic         resetn;
  logic         flush;
  logic [5:0]   stall;
  logic [101:0] ms_to_ws_bus;
  logic [37:0]  ws_to_rf_bus;
  logic [37:0]  ws_to_es_bus;
  logic         stallreq_trace;
  logic         debug_valid;
  logic         debug_ready;
  logic [31:0]  debug_wb_pc;
  logic [3:0]   debug_wb_rf_we;
  logic [4:0]   debug_wb_rf_wnum;
  logic [31:0]  debug_wb_rf_wdata;

  wb_stage #(
    .MS_TO_WS_BUS_WD(102),
    .WS_TO_RF_BUS_WD(38),
    .TRACE_DEPTH    (4)
  ) dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .stall            (stall),
    .ms_to_ws_bus     (ms_to_ws_bus),
    .ws_to_rf_bus     (ws_to_rf_bus),
    .ws_to_es_bus     (ws_to_es_bus),
    .stallreq_trace   (stallreq_trace),
    .debug_valid      (debug_valid),
    .debug_ready      (debug_ready),
    .debug_wb_pc      (debug_wb_pc),
    .debug_wb_rf_we   (debug_wb_rf_we),
    .debug_wb_rf_wnum (debug_wb_rf_wnum),
    .debug_wb_rf_wdata(debug_wb_rf_wdata)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [3:0]  we;
    logic [4:0]  wnum;
    logic [31:0] wdata;
  } trace_t;

  // Model: the instruction currently in the stage plus an ordered list of retired entries.
  trace_t      tq[$];
  logic [31:0] m_pc;
  logic [31:0] m_res;
  logic [4:0]  m_dest;
  logic        m_we;
  logic        m_pushed;

  localparam int unsigned Depth = 4;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [101:0] mk(input logic we, input logic [4:0] dest,
                                      input logic [31:0] res, input logic [31:0] pc);
    logic [31:0] inst;
    inst = $urandom;
    return {we, dest, res, pc, inst};
  endfunction

  task automatic model_reset();
    tq.delete();
    m_pc     = '0;
    m_res    = '0;
    m_dest   = '0;
    m_we     = 1'b0;
    m_pushed = 1'b0;
  endtask

  task automatic check_outputs();
    logic   valid, rfwe, pop, full, sreq;
    trace_t head;
    valid = (m_pc != 0);
    rfwe  = valid && m_we && (m_dest != 0);
    pop   = (tq.size() != 0) && debug_ready;
    full  = (tq.size() == Depth);
    sreq  = valid && !m_pushed && full && !pop;
    head  = '{pc: 0, we: 0, wnum: 0, wdata: 0};
    if (tq.size() != 0) head = tq[0];
    check_eq("rf_bus", 64'(ws_to_rf_bus), 64'({rfwe, m_dest, m_res}));
    check_eq("es_bus", 64'(ws_to_es_bus), 64'({rfwe, m_dest, m_res}));
    check_eq("stallreq", 64'(stallreq_trace), 64'(sreq));
    check_eq("dbg_valid", 64'(debug_valid), 64'(tq.size() != 0));
    check_eq("dbg_pc", 64'(debug_wb_pc), 64'(head.pc));
    check_eq("dbg_we", 64'(debug_wb_rf_we), 64'(head.we));
    check_eq("dbg_wnum", 64'(debug_wb_rf_wnum), 64'(head.wnum));
    check_eq("dbg_wdata", 64'(debug_wb_rf_wdata), 64'(head.wdata));
  endtask

  task automatic model_advance();
    logic   valid, rfwe, pop, push;
    trace_t e;
    valid = (m_pc != 0);
    rfwe  = valid && m_we && (m_dest != 0);
    pop   = (tq.size() != 0) && debug_ready;
    push  = valid && !m_pushed && ((tq.size() < Depth) || pop);
    e     = '{pc: m_pc, we: {4{rfwe}}, wnum: m_dest, wdata: m_res};
    if (pop) void'(tq.pop_front());
    if (push) tq.push_back(e);
    if (flush || !(stall[4] && stall[5])) begin
      m_pushed = 1'b0;
      if (!flush && !stall[4]) begin
        m_we   = ms_to_ws_bus[101];
        m_dest = ms_to_ws_bus[100:96];
        m_res  = ms_to_ws_bus[95:64];
        m_pc   = ms_to_ws_bus[63:32];
      end else begin
        m_we   = 1'b0;
        m_dest = '0;
        m_res  = '0;
        m_pc   = '0;
      end
    end else if (push) begin
      m_pushed = 1'b1;
    end
  endtask

  task automatic step(input logic [101:0] bus, input logic fl, input logic [5:0] st,
                      input logic rdy);
    @(negedge clk);
    ms_to_ws_bus = bus;
    flush        = fl;
    stall        = st;
    debug_ready  = rdy;
    #2;
    check_outputs();
    model_advance();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    resetn       = 1'b0;
    ms_to_ws_bus = '0;
    flush        = 1'b0;
    stall        = '0;
    debug_ready  = 1'b0;
    #1;
    check_eq("rst_dbg_valid", 64'(debug_valid), 64'(0));
    check_eq("rst_stallreq", 64'(stallreq_trace), 64'(0));
    check_eq("rst_rf_bus", 64'(ws_to_rf_bus), 64'(0));
    check_eq("rst_dbg_pc", 64'(debug_wb_pc), 64'(0));
    check_eq("rst_dbg_we", 64'(debug_wb_rf_we), 64'(0));
    check_eq("rst_dbg_wdata", 64'(debug_wb_rf_wdata), 64'(0));
    model_reset();
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #2;
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step('0, 1'b0, 6'h00, 1'b1);
  endtask

  initial begin
    logic [101:0] b;
    logic [5:0]   st;
    resetn       = 1'b0;
    flush        = 1'b0;
    stall        = '0;
    debug_ready  = 1'b0;
    ms_to_ws_bus = '0;
    model_reset();
    #12;
    check_eq("reset_dbg_valid", 64'(debug_valid), 64'(0));
    check_eq("reset_rf_bus", 64'(ws_to_rf_bus), 64'(0));
    check_eq("reset_stallreq", 64'(stallreq_trace), 64'(0));
    check_eq("reset_dbg_fields",
             64'({debug_wb_rf_we, debug_wb_rf_wnum}) | 64'(debug_wb_pc | debug_wb_rf_wdata),
             64'(0));
    @(negedge clk);
    resetn = 1'b1;
    @(posedge clk);
    #2;

    // Single retire
    step(mk(1'b1, 5'd5, 32'h1234, 32'h1C00_0000), 1'b0, 6'h00, 1'b0);
    check_eq("retire_rf_bus", 64'(ws_to_rf_bus), 64'({1'b1, 5'd5, 32'h1234}));
    step('0, 1'b0, 6'h00, 1'b0);
    check_eq("retire_dbg_valid", 64'(debug_valid), 64'(1));
    check_eq("retire_dbg_pc", 64'(debug_wb_pc), 64'(32'h1C00_0000));
    check_eq("retire_dbg_we", 64'(debug_wb_rf_we), 64'(4'hF));
    drain(2);

    // r0 write is traced but not written
    step(mk(1'b1, 5'd0, 32'h55, 32'h1C00_0010), 1'b0, 6'h00, 1'b0);
    check_eq("r0_rf_we", 64'(ws_to_rf_bus[37]), 64'(0));
    step('0, 1'b0, 6'h00, 1'b0);
    check_eq("r0_dbg_valid", 64'(debug_valid), 64'(1));
    check_eq("r0_dbg_we", 64'(debug_wb_rf_we), 64'(0));
    drain(2);

    // Full buffer and back-pressure
    for (int i = 0; i < 5; i++) step(mk(1'b1, 5'(i + 1), 32'(i), 32'h2000 + 32'(4 * i)), 1'b0,
                                     6'h00, 1'b0);
    check_eq("full_stallreq", 64'(stallreq_trace), 64'(1));
    step(mk(1'b1, 5'd9, 32'h9, 32'h3000), 1'b0, 6'h3f, 1'b0);
    check_eq("full_hold_stallreq", 64'(stallreq_trace), 64'(1));
    check_eq("full_hold_rf_bus", 64'(ws_to_rf_bus), 64'({1'b1, 5'd5, 32'd4}));
    step(mk(1'b1, 5'd9, 32'h9, 32'h3000), 1'b0, 6'h3f, 1'b1);
    check_eq("pulse_stallreq", 64'(stallreq_trace), 64'(0));
    check_eq("pulse_head_pc", 64'(debug_wb_pc), 64'(32'h2004));
    drain(6);
    check_eq("drained_valid", 64'(debug_valid), 64'(0));

    // Stall held with a valid instruction: one entry only
    step(mk(1'b1, 5'd7, 32'h77, 32'h4000), 1'b0, 6'h00, 1'b0);
    for (int i = 0; i < 3; i++) step(mk(1'b1, 5'd8, 32'h88, 32'h4004), 1'b0, 6'h3f, 1'b0);
    step('0, 1'b0, 6'h00, 1'b1);
    step('0, 1'b0, 6'h00, 1'b1);
    check_eq("stall_no_dup", 64'(debug_valid), 64'(0));

    // Flush with two entries buffered, then flush coinciding with a push
    step(mk(1'b1, 5'd1, 32'hA, 32'h5000), 1'b0, 6'h00, 1'b0);
    step(mk(1'b1, 5'd2, 32'hB, 32'h5004), 1'b0, 6'h00, 1'b0);
    step('0, 1'b0, 6'h00, 1'b0);
    step(mk(1'b1, 5'd3, 32'hC, 32'h5008), 1'b1, 6'h00, 1'b0);
    check_eq("flush_rf_bus", 64'(ws_to_rf_bus), 64'(0));
    check_eq("flush_head_pc", 64'(debug_wb_pc), 64'(32'h5000));
    step(mk(1'b1, 5'd4, 32'hD, 32'h500C), 1'b0, 6'h00, 1'b0);
    step('0, 1'b1, 6'h00, 1'b0);
    drain(4);

    // Asynchronous reset discards buffered entries
    step(mk(1'b1, 5'd6, 32'hE, 32'h6000), 1'b0, 6'h00, 1'b0);
    step(mk(1'b1, 5'd6, 32'hF, 32'h6004), 1'b0, 6'h00, 1'b0);
    do_reset();

    // Pointer wrap with continuous draining
    for (int i = 0; i < 10; i++) step(mk(1'b1, 5'd10, 32'(i), 32'h7000 + 32'(4 * i)), 1'b0,
                                      6'h00, 1'b1);
    drain(3);

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        b = mk(1'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
               $urandom, ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom | 32'h4));
        case ($urandom_range(0, 9))
          0:       st = 6'h10;
          1:       st = 6'h3f;
          2:       st = 6'($urandom);
          default: st = 6'h00;
        endcase
        if (m_pc != 0 && !m_pushed && tq.size() == Depth && $urandom_range(0, 4) != 0) st = 6'h3f;
        step(b, ($urandom_range(0, 24) == 0), st, 1'($urandom_range(0, 2) != 0));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter MS_TO_WS_BUS_WD, default 102, width of the incoming memory-stage bus.
REQ-002 Parameter WS_TO_RF_BUS_WD, default 38, width of the regfile write bus {we, waddr[4:0], wdata[31:0]}.
REQ-003 Parameter TRACE_DEPTH, default 4, depth of the retire-trace buffer; power of two, at least 2.
REQ-004 clk  in  1  single clock; every flop updates on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous and active-low.
REQ-006 flush  in  1  exception flush from the memory stage.
REQ-007 stall  in  6  pipeline stall vector; this stage uses bits [4] and [5].
REQ-008 ms_to_ws_bus  in  MS_TO_WS_BUS_WD  fields: reg_we [101], dest [100:96], result [95:64], pc [63:32], inst [31:0].
REQ-009 ws_to_rf_bus  out  WS_TO_RF_BUS_WD  regfile write port {rf_we, rf_waddr, rf_wdata}.
REQ-010 ws_to_es_bus  out  38  forwarding bus to execute, same packing as ws_to_rf_bus.
REQ-011 stallreq_trace  out  1  stall request to pipeline control; asserted when the trace buffer cannot accept a retire.
REQ-012 debug_valid  out  1  trace head entry valid.
REQ-013 debug_ready  in  1  trace consumer accepts the head entry.
REQ-014 debug_wb_pc / debug_wb_rf_we / debug_wb_rf_wnum / debug_wb_rf_wdata  out  32/4/5/32  trace head entry fields.

Function
REQ-015 Stage register ws_bus_r: cleared to 0 on flush; loaded with 0 (bubble) when stall[4]&!stall[5]; loaded with ms_to_ws_bus when !stall[4]; held otherwise.
REQ-016 ws_valid = (ws pc != 0); an all-zero register is a bubble.
REQ-017 rf_we = ws_valid & reg_we & (dest != 0); rf_waddr = dest; rf_wdata = result. The path is combinational from ws_bus_r, zero added latency. A held register rewrites the same value, which is harmless.
REQ-018 ws_to_es_bus carries the same rf_we, rf_waddr and rf_wdata as ws_to_rf_bus.
REQ-019 Flag ws_pushed: cleared whenever ws_bus_r is loaded or cleared; set on the cycle the current instruction is pushed into the trace buffer. Each retired instruction is pushed exactly once.
REQ-020 push = ws_valid & !ws_pushed & (!full | pop); pop = debug_valid & debug_ready.
REQ-021 Trace entry = {pc, {4{rf_we}}, dest, result}. A push writes the entry at wr_ptr.
REQ-022 wr_ptr and rd_ptr are log2(TRACE_DEPTH) bits and wrap modulo TRACE_DEPTH. count runs 0..TRACE_DEPTH. full = (count == TRACE_DEPTH); empty = (count == 0).
REQ-023 Simultaneous push and pop: count is unchanged and both pointers advance. This includes the full case, where the popped slot is reused in the same cycle.
REQ-024 debug_valid = !empty. The debug_wb_* outputs show the entry at rd_ptr (first-word fall-through) and hold stable while debug_valid & !debug_ready.
REQ-025 stallreq_trace = ws_valid & !ws_pushed & full & !pop, combinational. Pipeline control answers it with stall[5:0] set, so ws_bus_r holds.
REQ-026 Flush clears ws_bus_r and ws_pushed but does not touch trace-buffer contents or pointers. Entries already in the buffer are committed.
REQ-027 A flush in the same cycle as a push still completes the push, because the instruction in the stage has already retired.
REQ-028 Pop when empty is ignored; debug_ready is don't-care when debug_valid = 0.

Reset
REQ-029 While resetn = 0: ws_bus_r = 0, ws_pushed = 0, wr_ptr = rd_ptr = 0, count = 0.
REQ-030 Resulting output values during reset: rf_we = 0, debug_valid = 0, stallreq_trace = 0, all debug_wb_* outputs = 0.
REQ-031 Buffer storage need not be reset; debug_wb_* are forced to 0 while empty.
REQ-032 Asserting resetn low mid-operation discards all buffered entries asynchronously.

Verification
REQ-033 Single retire: with stall = 0, bus {we=1, dest=5, result=0x1234, pc=0x1C000000}.
  - Next cycle: rf_we = 1, waddr = 5, wdata = 0x1234.
  - One cycle later: debug_valid = 1, pc = 0x1C000000, debug_wb_rf_we = 0xF.
REQ-034 r0 write: dest = 0, we = 1.
  - rf_we = 0.
  - Trace entry still pushed, with debug_wb_rf_we = 0x0.
REQ-035 Full buffer: debug_ready = 0 for 5 consecutive valid retires.
  - First 4 are buffered; the 5th raises stallreq_trace = 1 and ws_bus_r holds.
  - Pulsing debug_ready for one cycle drops stallreq_trace, pushes the 5th, and count stays 4.
REQ-036 Stall held 3 cycles with a valid instruction in the stage: exactly one trace entry and no duplicate pushes.
REQ-037 Flush with 2 entries buffered: ws_bus_r becomes 0 next cycle, count stays 2, and the entries drain in order with pcs intact.
REQ-038 Pointer wrap: 10 retires with debug_ready = 1 throughout.
  - Trace emits all 10 pcs in order with no stallreq_trace.
  - Pointers wrap twice at TRACE_DEPTH = 4.
